scoreboard_slot_table: RTL
==========================

// Module: scoreboard_slot_table
// PURPOSE
//  Slot-tracking table for the buffet scoreboard. Producers allocate a free slot and deposit a payload; a consumer
//  reads a slot by index and optionally retires it, returning it to the free pool. Allocation picks the
//  highest-index free slot, the same rule as the scoreboard free-slot encoder. Index-to-slot selection on the
//  read/retire side uses a one-hot decoder. Sits between the buffet fill logic and the scoreboard drain logic.
// PARAMETERS
//  WIDTH       `SCOREBOARD_SIZE (8)  number of slots
//  DATA_WIDTH  32                    payload bits per slot
//  IDXW        $clog2(WIDTH)         index width (localparam, derived)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  nreset         in   1           asynchronous active-low reset
//  alloc_valid    in   1           producer requests a slot
//  alloc_data     in   DATA_WIDTH  payload written into the granted slot
//  alloc_ready    out  1           a free slot exists (= ~full)
//  alloc_idx      out  IDXW        slot granted when alloc_valid && alloc_ready
//  rd_valid       in   1           read request (always accepted, no backpressure)
//  rd_idx         in   IDXW        slot to read
//  rd_retire      in   1           free the slot after reading (qualified by rd_valid)
//  rd_resp_valid  out  1           response valid, 1 cycle after rd_valid
//  rd_resp_hit    out  1           slot was occupied when sampled
//  rd_resp_data   out  DATA_WIDTH  slot payload; 0 on miss
//  full           out  1           all slots occupied
//  empty          out  1           no slot occupied
//  err_dbl_free   out  1           1-cycle pulse: retire of unoccupied or out-of-range slot
//  occ_count      out  IDXW+1      occupied-slot count (only with SCOREBOARD_OCC_COUNT_EN)
// BEHAVIOUR
//  - State: occ[WIDTH-1:0], mem[WIDTH][DATA_WIDTH]. Async reset: occ=0, rd_resp_valid=0, rd_resp_hit=0,
//    rd_resp_data=0, err_dbl_free=0, occ_count=0. mem is not reset; reading it after reset returns hit=0, data=0.
//  - alloc_idx: combinational from registered occ. It is the highest i with occ[i]==0, or 0 when full.
//    alloc_ready=~full. A fire (alloc_valid&&alloc_ready) sets occ[idx]<=1 and mem[idx]<=alloc_data at the edge.
//    alloc_valid while full has no effect.
//  - Read: on rd_valid, next cycle rd_resp_valid=1, rd_resp_hit=occ[rd_idx], and rd_resp_data=mem[rd_idx] if hit,
//    else 0. All values are sampled pre-edge. Back-to-back reads every cycle are supported.
//  - Retire: rd_valid&&rd_retire&&hit clears occ[rd_idx] at the same edge. The response still reports hit=1 and the
//    stored data. Retire on a miss leaves state unchanged; err_dbl_free=1 next cycle.
//  - rd_idx>=WIDTH (non-power-of-2 WIDTH) is treated as a miss.
//  - Simultaneous alloc and retire: both apply. The alloc uses pre-edge occ, so it never targets the slot being
//    retired in that cycle. full/alloc_ready update only from the registered occ; a retire while full opens
//    alloc_ready on the following cycle (no same-cycle bypass).
//  - Read of the slot being allocated in the same cycle returns a miss, because pre-edge occ=0.
//  - full=&occ and empty=~|occ, both derived from registered state.
//  - Reset asserted mid-operation clears all occupancy immediately. An in-flight response is dropped.
// CONFIGURATION
//  SCOREBOARD_OCC_COUNT_EN defined:
//    occ_count port exists, registered, updated +1/-1/0 per cycle (alloc fire, hit retire, both).
//    It always equals popcount(occ).
//  Undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package scoreboard_pkg: SCOREBOARD_SIZE, SB_IDXW, SB_DATA_WIDTH, and an sb_idx_t typedef.
//  - Sub-module scoreboard_onehot_decoder (IDXW in -> WIDTH one-hot, plus in-range flag). It drives the
//    occ-clear mask and the read-mux select.
//  - Free-slot selection reuses the existing scoreboard priority encoder.
// TESTING
//  1. Reset, then 8 allocs with data 0xA0..0xA7 -> alloc_idx 7,6,...,0; full=1 after the 8th; alloc_ready=0.
//  2. Full table, read idx 3 with retire -> next cycle hit=1, data=0xA4; the cycle after, alloc_ready=1,
//     alloc_idx=3.
//  3. Retire idx 5 twice -> 1st: hit=1; 2nd: hit=0, data=0, err_dbl_free pulses exactly 1 cycle, occ unchanged.
//  4. Same cycle: alloc (idx 7 free) + retire idx 2 (occupied) -> both take effect.
//     occ[7]=1, occ[2]=0; with the count option enabled, occ_count is unchanged.
//  5. Read idx 6 in the same cycle it is allocated -> miss. Read next cycle -> hit with the new data.
//  6. Assert nreset mid-stream with 4 slots full and a read in flight -> outputs zero immediately, empty=1,
//     alloc_idx=7, no stale rd_resp_valid.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
//  Constants and types shared by the scoreboard slot-table files.
//  SCOREBOARD_SIZE : default number of scoreboard slots
//  SB_IDXW         : slot index width derived from SCOREBOARD_SIZE
//  SB_DATA_WIDTH   : default payload width per slot
//  sb_idx_t        : slot index type
// -----------------------------------------------------------------------------
package scoreboard_pkg;

   localparam int SCOREBOARD_SIZE = 8;
   localparam int SB_IDXW         = $clog2(SCOREBOARD_SIZE);
   localparam int SB_DATA_WIDTH   = 32;

   typedef logic [SB_IDXW-1:0] sb_idx_t;

endpackage : scoreboard_pkg

// File: rtl/scoreboard_onehot_decoder.sv
// -----------------------------------------------------------------------------
// scoreboard_onehot_decoder
//  Converts a binary slot index into a one-hot slot select. Purely
//  combinational.
//  Ports:
//   idx       in   IDXW   binary slot index
//   onehot    out  WIDTH  one-hot select, all zero when idx >= WIDTH
//   in_range  out  1      idx addresses an existing slot
// -----------------------------------------------------------------------------
module scoreboard_onehot_decoder
   import scoreboard_pkg::*;
#(
   parameter int WIDTH = SCOREBOARD_SIZE,
   parameter int IDXW  = $clog2(WIDTH)
)(
   input  logic [IDXW-1:0]  idx,
   output logic [WIDTH-1:0] onehot,
   output logic             in_range
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
         assign onehot[gi] = (idx == IDXW'(gi));
      end
   endgenerate

   // An index past the last slot decodes to no bit at all.
   assign in_range = |onehot;

endmodule : scoreboard_onehot_decoder

// File: rtl/scoreboard_slot_table.sv
// -----------------------------------------------------------------------------
// scoreboard_slot_table
//  Slot-tracking table between the buffet fill logic and the scoreboard drain
//  logic. Producers allocate the highest-index free slot and store a payload;
//  a consumer reads a slot by index and may retire it back to the free pool.
//
//  Optional feature (compile-time macro SCOREBOARD_OCC_COUNT_EN):
//   adds the registered occ_count port tracking the number of occupied slots.
//
//  Ports:
//   clk            in   1           clock, rising edge
//   nreset         in   1           asynchronous active-low reset
//   alloc_valid    in   1           producer requests a slot
//   alloc_data     in   DATA_WIDTH  payload for the granted slot
//   alloc_ready    out  1           a free slot exists
//   alloc_idx      out  IDXW        slot granted on alloc_valid && alloc_ready
//   rd_valid       in   1           read request, always accepted
//   rd_idx         in   IDXW        slot to read
//   rd_retire      in   1           free the slot after reading
//   rd_resp_valid  out  1           response valid, one cycle after rd_valid
//   rd_resp_hit    out  1           slot was occupied when sampled
//   rd_resp_data   out  DATA_WIDTH  slot payload, zero on a miss
//   full           out  1           all slots occupied
//   empty          out  1           no slot occupied
//   err_dbl_free   out  1           one-cycle pulse on retire of a free slot
//   occ_count      out  IDXW+1      occupied-slot count (optional)
// -----------------------------------------------------------------------------
module scoreboard_slot_table
   import scoreboard_pkg::*;
#(
   parameter  int WIDTH      = SCOREBOARD_SIZE,
   parameter  int DATA_WIDTH = SB_DATA_WIDTH,
   localparam int IDXW       = $clog2(WIDTH)
)(
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  alloc_valid,
   input  logic [DATA_WIDTH-1:0] alloc_data,
   output logic                  alloc_ready,
   output logic [IDXW-1:0]       alloc_idx,
   input  logic                  rd_valid,
   input  logic [IDXW-1:0]       rd_idx,
   input  logic                  rd_retire,
   output logic                  rd_resp_valid,
   output logic                  rd_resp_hit,
   output logic [DATA_WIDTH-1:0] rd_resp_data,
   output logic                  full,
   output logic                  empty,
   output logic                  err_dbl_free
`ifdef SCOREBOARD_OCC_COUNT_EN
   ,
   output logic [IDXW:0]         occ_count
`endif
);

   logic [WIDTH-1:0]      occ_reg;
   logic [WIDTH-1:0]      occ_next;
   logic [WIDTH-1:0]      alloc_mask;
   logic [WIDTH-1:0]      rd_sel;
   logic                  rd_in_range;
   logic                  rd_hit;
   logic                  alloc_fire;
   logic                  retire_hit;
   logic                  retire_miss;
   logic [IDXW-1:0]       free_idx;

   logic                  resp_valid_reg;
   logic                  resp_hit_reg;
   logic                  err_dbl_free_reg;
   logic [DATA_WIDTH-1:0] rd_data_reg;

   // Payload storage; no reset so it maps onto block RAM.
   logic [DATA_WIDTH-1:0] mem [WIDTH];

   // ---------------------------------------------------------------------
   // Free-slot priority encoder: ascending scan, so the last match (the
   // highest free index) wins. Falls back to 0 when the table is full.
   // ---------------------------------------------------------------------
   always_comb begin
      free_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!occ_reg[i]) begin
            free_idx = IDXW'(i);
         end
      end
   end

   assign full        = &occ_reg;
   assign empty       = ~|occ_reg;
   assign alloc_ready = ~full;
   assign alloc_idx   = free_idx;
   assign alloc_fire  = alloc_valid & alloc_ready;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alloc_mask
         assign alloc_mask[gi] = alloc_fire && (free_idx == IDXW'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read/retire slot select
   // ---------------------------------------------------------------------
   scoreboard_onehot_decoder #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_rd_dec (
      .idx      (rd_idx),
      .onehot   (rd_sel),
      .in_range (rd_in_range)
   );

   // Hit is judged on pre-edge occupancy, so a slot allocated this cycle
   // still reads as a miss.
   assign rd_hit      = rd_in_range & (|(occ_reg & rd_sel));
   assign retire_hit  = rd_valid & rd_retire & rd_hit;
   assign retire_miss = rd_valid & rd_retire & ~rd_hit;

   // The alloc target is always a free slot and the retire target is always
   // an occupied one, so the set and clear masks never overlap.
   assign occ_next = (occ_reg & ~({WIDTH{retire_hit}} & rd_sel)) | alloc_mask;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         occ_reg          <= '0;
         resp_valid_reg   <= 1'b0;
         resp_hit_reg     <= 1'b0;
         err_dbl_free_reg <= 1'b0;
      end else begin
         occ_reg          <= occ_next;
         resp_valid_reg   <= rd_valid;
         resp_hit_reg     <= rd_valid & rd_hit;
         err_dbl_free_reg <= retire_miss;
      end
   end

   // Write port and registered read port of the payload RAM. A read of an
   // out-of-range or free slot returns whatever is stored, but the output
   // mux below masks it to zero.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         mem[free_idx] <= alloc_data;
      end
      if (rd_valid) begin
         rd_data_reg <= mem[rd_idx];
      end
   end

   assign rd_resp_valid = resp_valid_reg;
   assign rd_resp_hit   = resp_hit_reg;
   assign rd_resp_data  = resp_hit_reg ? rd_data_reg : '0;
   assign err_dbl_free  = err_dbl_free_reg;

`ifdef SCOREBOARD_OCC_COUNT_EN
   // ---------------------------------------------------------------------
   // Occupancy counter, tracks popcount(occ_reg) incrementally.
   // ---------------------------------------------------------------------
   logic [IDXW:0] occ_count_reg;
   logic [IDXW:0] occ_count_next;

   always_comb begin
      occ_count_next = occ_count_reg;
      case ({alloc_fire, retire_hit})
         2'b10:   occ_count_next = occ_count_reg + 1'b1;
         2'b01:   occ_count_next = occ_count_reg - 1'b1;
         default: occ_count_next = occ_count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         occ_count_reg <= '0;
      end else begin
         occ_count_reg <= occ_count_next;
      end
   end

   assign occ_count = occ_count_reg;
`endif

endmodule : scoreboard_slot_table
